// File: rtl/quad_decoder.sv
// quad_decoder: Gray-code quadrature decoder; A_i/B_i in, pos_o count, up_o/down_o step pulses, dir_o last direction, err_o sticky illegal flag
module quad_decoder #(
  parameter int WIDTH_P  = 8,
  parameter int DETENT_P = 4,
  parameter int WRAP_P   = 1
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               A_i,
  input  logic               B_i,
  input  logic               clear_i,
  output logic [WIDTH_P-1:0] pos_o,
  output logic               up_o,
  output logic               down_o,
  output logic               dir_o,
  output logic               err_o
);
  localparam logic signed [3:0] DET = 4'(DETENT_P);
  logic [1:0] prev_ab, cur;
  logic signed [3:0] acc, acc_up, acc_dn;
  logic fwd, rev, bad, up_step, dn_step, can_up, can_dn;
  always_comb begin
    cur = {A_i, B_i};
    fwd = (prev_ab == 2'b00 && cur == 2'b10) || (prev_ab == 2'b10 && cur == 2'b11) ||
          (prev_ab == 2'b11 && cur == 2'b01) || (prev_ab == 2'b01 && cur == 2'b00);
    rev = (prev_ab == 2'b00 && cur == 2'b01) || (prev_ab == 2'b01 && cur == 2'b11) ||
          (prev_ab == 2'b11 && cur == 2'b10) || (prev_ab == 2'b10 && cur == 2'b00);
    bad = cur == ~prev_ab;
    acc_up = acc + 4'sd1;
    acc_dn = acc - 4'sd1;
    up_step = fwd && acc_up == DET;
    dn_step = rev && acc_dn == -DET;
    // a saturating counter swallows the step (and its pulse) at the rail
    can_up = WRAP_P != 0 || !(&pos_o);
    can_dn = WRAP_P != 0 || |pos_o;
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      prev_ab <= cur;
      acc <= '0;
      pos_o <= '0;
      up_o <= 1'b0;
      down_o <= 1'b0;
      dir_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      prev_ab <= cur;
      up_o <= 1'b0;
      down_o <= 1'b0;
      if (clear_i) begin
        pos_o <= '0;
        acc <= '0;
        err_o <= 1'b0;
      end else if (bad) begin
        err_o <= 1'b1;
        acc <= '0;
      end else if (up_step) begin
        acc <= '0;
        if (can_up) begin
          pos_o <= pos_o + 1'b1;
          up_o <= 1'b1;
          dir_o <= 1'b1;
        end
      end else if (dn_step) begin
        acc <= '0;
        if (can_dn) begin
          pos_o <= pos_o - 1'b1;
          down_o <= 1'b1;
          dir_o <= 1'b0;
        end
      end else if (fwd) begin
        acc <= acc_up;
      end else if (rev) begin
        acc <= acc_dn;
      end
    end
  end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed checks of a wrapping and a saturating decoder driven by the same encoder inputs
module tb_quad_decoder;
  logic clk = 0, reset = 1, a = 0, b = 0, clear = 0;
  logic [7:0] pos_w, pos_s;
  logic up_w, down_w, dir_w, err_w, up_s, down_s, dir_s, err_s;
  logic p_up_w, p_dn_w, p_up_s, p_dn_s;
  int n_up_w = 0, n_dn_w = 0, n_up_s = 0, n_dn_s = 0;
  int checks = 0, fails = 0;
  int bu, bd, bus, bds;

  quad_decoder #(.WIDTH_P(8), .DETENT_P(4), .WRAP_P(1)) dut_w (
    .clk(clk), .reset_i(reset), .A_i(a), .B_i(b), .clear_i(clear),
    .pos_o(pos_w), .up_o(up_w), .down_o(down_w), .dir_o(dir_w), .err_o(err_w));
  quad_decoder #(.WIDTH_P(8), .DETENT_P(4), .WRAP_P(0)) dut_s (
    .clk(clk), .reset_i(reset), .A_i(a), .B_i(b), .clear_i(clear),
    .pos_o(pos_s), .up_o(up_s), .down_o(down_s), .dir_o(dir_s), .err_o(err_s));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (up_w) n_up_w++;
    if (down_w) n_dn_w++;
    if (up_s) n_up_s++;
    if (down_s) n_dn_s++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] ab);
    {a, b} = ab;
    clear = 0;
    reset = 1;
    repeat (3) tick();
    reset = 0;
    tick();
  endtask

  task automatic trans(input logic [1:0] ab, input int hold);
    {a, b} = ab;
    tick();
    p_up_w = up_w; p_dn_w = down_w; p_up_s = up_s; p_dn_s = down_s;
    repeat (hold - 1) tick();
  endtask

  task automatic fwd_cycle(input int hold);
    trans(2'b10, hold); trans(2'b11, hold); trans(2'b01, hold); trans(2'b00, hold);
  endtask

  task automatic rev_cycle(input int hold);
    trans(2'b01, hold); trans(2'b11, hold); trans(2'b10, hold); trans(2'b00, hold);
  endtask

  task automatic snap();
    bu = n_up_w; bd = n_dn_w; bus = n_up_s; bds = n_dn_s;
  endtask

  task automatic test_reset();
    {a, b} = 2'b11;
    reset = 1;
    repeat (3) tick();
    snap();
    reset = 0;
    repeat (10) tick();
    checks++; if (pos_w !== 8'd0) begin fails++; $display("FAIL reset_pos got %0d exp 0", pos_w); end
    checks++; if (n_up_w + n_dn_w - bu - bd !== 0) begin fails++; $display("FAIL reset_pulses got %0d exp 0", n_up_w + n_dn_w - bu - bd); end
    checks++; if ({err_w, err_s, dir_w, up_w, down_w} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b exp 00000", {err_w, err_s, dir_w, up_w, down_w}); end
  endtask

  task automatic test_forward();
    do_reset(2'b00);
    snap();
    for (int i = 1; i <= 3; i++) begin
      trans(2'b10, 5); trans(2'b11, 5); trans(2'b01, 5);
      checks++; if (pos_w !== 8'(i - 1)) begin fails++; $display("FAIL fwd_mid%0d got %0d exp %0d", i, pos_w, i - 1); end
      trans(2'b00, 5);
      checks++; if (p_up_w !== 1'b1) begin fails++; $display("FAIL fwd_pulse%0d got %b exp 1", i, p_up_w); end
    end
    checks++; if (n_up_w - bu !== 3) begin fails++; $display("FAIL fwd_count got %0d exp 3", n_up_w - bu); end
    checks++; if (pos_w !== 8'd3 || pos_s !== 8'd3) begin fails++; $display("FAIL fwd_pos got %0d/%0d exp 3/3", pos_w, pos_s); end
    checks++; if (dir_w !== 1'b1) begin fails++; $display("FAIL fwd_dir got %b exp 1", dir_w); end
  endtask

  task automatic test_reverse_wrap();
    do_reset(2'b00);
    snap();
    rev_cycle(3);
    checks++; if (n_dn_w - bd !== 1 || p_dn_w !== 1'b1) begin fails++; $display("FAIL wrap_down got %0d exp 1", n_dn_w - bd); end
    checks++; if (pos_w !== 8'd255) begin fails++; $display("FAIL wrap_pos got %0d exp 255", pos_w); end
    checks++; if (dir_w !== 1'b0) begin fails++; $display("FAIL wrap_dir got %b exp 0", dir_w); end
    snap();
    trans(2'b10, 3); trans(2'b11, 3); trans(2'b10, 3); trans(2'b00, 3);
    checks++; if (n_up_w + n_dn_w - bu - bd !== 0) begin fails++; $display("FAIL reversal_pulses got %0d exp 0", n_up_w + n_dn_w - bu - bd); end
    checks++; if (pos_w !== 8'd255) begin fails++; $display("FAIL reversal_pos got %0d exp 255", pos_w); end
  endtask

  task automatic test_saturation();
    do_reset(2'b00);
    snap();
    rev_cycle(2); rev_cycle(2);
    checks++; if (pos_s !== 8'd0) begin fails++; $display("FAIL sat_pos got %0d exp 0", pos_s); end
    checks++; if (n_dn_s - bds !== 0) begin fails++; $display("FAIL sat_down got %0d exp 0", n_dn_s - bds); end
    checks++; if (pos_w !== 8'd254) begin fails++; $display("FAIL sat_wrap_pos got %0d exp 254", pos_w); end
    fwd_cycle(2); fwd_cycle(2);
    checks++; if (pos_s !== 8'd2 || dir_s !== 1'b1) begin fails++; $display("FAIL sat_fwd got pos %0d dir %b exp pos 2 dir 1", pos_s, dir_s); end
    checks++; if (pos_w !== 8'd0) begin fails++; $display("FAIL wrap_up got %0d exp 0", pos_w); end
  endtask

  task automatic test_illegal();
    do_reset(2'b00);
    snap();
    trans(2'b10, 2);
    trans(2'b01, 2);
    checks++; if (err_w !== 1'b1 || err_s !== 1'b1) begin fails++; $display("FAIL illegal_err got %b%b exp 11", err_w, err_s); end
    checks++; if (pos_w !== 8'd0 || p_up_w !== 1'b0 || p_dn_w !== 1'b0) begin fails++; $display("FAIL illegal_pos got %0d exp 0", pos_w); end
    trans(2'b00, 2); trans(2'b10, 2); trans(2'b11, 2);
    checks++; if (n_up_w - bu !== 0) begin fails++; $display("FAIL illegal_acc got %0d ups exp 0", n_up_w - bu); end
    trans(2'b01, 2);
    checks++; if (n_up_w - bu !== 1 || pos_w !== 8'd1) begin fails++; $display("FAIL illegal_recover got %0d ups pos %0d exp 1 ups pos 1", n_up_w - bu, pos_w); end
    checks++; if (err_w !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", err_w); end
    clear = 1; tick(); clear = 0; tick();
    checks++; if (err_w !== 1'b0 || pos_w !== 8'd0) begin fails++; $display("FAIL clear got err %b pos %0d exp err 0 pos 0", err_w, pos_w); end
  endtask

  task automatic test_clear_collision();
    do_reset(2'b00);
    repeat (5) fwd_cycle(2);
    checks++; if (pos_w !== 8'd5) begin fails++; $display("FAIL coll_setup got %0d exp 5", pos_w); end
    snap();
    trans(2'b10, 2); trans(2'b11, 2); trans(2'b01, 2);
    clear = 1;
    trans(2'b00, 1);
    clear = 0;
    tick();
    checks++; if (pos_w !== 8'd0 || n_up_w - bu !== 0) begin fails++; $display("FAIL coll_clear got pos %0d ups %0d exp pos 0 ups 0", pos_w, n_up_w - bu); end
    checks++; if (dir_w !== 1'b1) begin fails++; $display("FAIL coll_dir got %b exp 1", dir_w); end
    fwd_cycle(2);
    checks++; if (pos_w !== 8'd1) begin fails++; $display("FAIL coll_next got %0d exp 1", pos_w); end
  endtask

  task automatic test_reset_mid_detent();
    do_reset(2'b00);
    trans(2'b10, 2); trans(2'b11, 2);
    do_reset(2'b11);
    snap();
    repeat (5) tick();
    trans(2'b01, 2); trans(2'b00, 2);
    checks++; if (n_up_w - bu !== 0 || pos_w !== 8'd0) begin fails++; $display("FAIL mid_reset got ups %0d pos %0d exp 0 0", n_up_w - bu, pos_w); end
    trans(2'b10, 2); trans(2'b11, 2);
    checks++; if (n_up_w - bu !== 1 || pos_w !== 8'd1) begin fails++; $display("FAIL mid_reset_step got ups %0d pos %0d exp 1 1", n_up_w - bu, pos_w); end
  endtask

  task automatic test_back_to_back();
    do_reset(2'b00);
    snap();
    fwd_cycle(1); fwd_cycle(1); rev_cycle(1);
    repeat (2) tick();
    checks++; if (n_up_w - bu !== 2 || n_dn_w - bd !== 1) begin fails++; $display("FAIL b2b_pulses got up %0d down %0d exp 2 1", n_up_w - bu, n_dn_w - bd); end
    checks++; if (pos_w !== 8'd1 || dir_w !== 1'b0) begin fails++; $display("FAIL b2b_pos got %0d dir %b exp 1 0", pos_w, dir_w); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_saturation();
    test_illegal();
    test_clear_collision();
    test_reset_mid_detent();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
